ball_tracker: RTL and testbench

BALL_TRACKER -- requirements
Module: ball_tracker

---
 rtl/ball_tracker.sv | 104 ++++++++++
 tb/tb_ball_tracker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_tracker.sv
// ball_tracker: debounces hole sensors, counts remaining balls and queues hole events
// for a downstream consumer; overflow flags events lost while a hole was still pending.
module ball_tracker #(
    parameter int N_HOLES    = 8,
    parameter int DB_LEN     = 5,
    parameter int BALLS_INIT = 8,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_HOLES-1:0]            ball,
    input  logic [2:0]                    state,
    output logic [N_HOLES-1:0]            getball,
    output logic [CNT_W-1:0]              ball_num,
    output logic                          balls_out,
    output logic                          ev_valid,
    output logic [$clog2(N_HOLES)-1:0]    ev_hole,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow
);
    localparam int HW = $clog2(N_HOLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(N_HOLES + 1);

    logic [N_HOLES-1:0] s1, s2, level, pending, all1, all0, push_mask, lost;
    logic [DB_LEN-1:0]  sh [N_HOLES];
    logic [HW-1:0]      mem [FIFO_DEPTH];
    logic [HW-1:0]      idx;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]      cnt;
    logic [CNT_W-1:0]   ball_next;
    logic               is_get, is_rst, pop, found, push;

    always_comb begin
        is_get = state == 3'd3;
        is_rst = state == 3'd0;
        pop = ev_valid && ev_ready;
        found = 1'b0;
        idx = '0;
        cnt = '0;
        for (int i = N_HOLES - 1; i >= 0; i--) begin
            all1[i] = &sh[i];
            all0[i] = ~|sh[i];
            cnt = cnt + PW'(getball[i]);
            if (pending[i]) begin
                found = 1'b1;
                idx = HW'(i);
            end
        end
        // The full check uses occupancy after this cycle's pop so a full queue can stream.
        push = found && !is_rst && ((ev_count - CW'(pop)) != CW'(FIFO_DEPTH));
        push_mask = push ? (N_HOLES'(1) << idx) : '0;
        lost = is_get ? (getball & pending & ~push_mask) : '0;
        ball_next = ({{PW{1'b0}}, ball_num} > {{CNT_W{1'b0}}, cnt}) ? ball_num - CNT_W'(cnt) : '0;
    end

    assign ev_valid  = ev_count != '0;
    assign ev_hole   = mem[rd_ptr];
    assign balls_out = ball_num == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            level <= '0;
            getball <= '0;
            for (int i = 0; i < N_HOLES; i++) sh[i] <= '0;
            ball_num <= CNT_W'(BALLS_INIT);
            pending <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            s1 <= ball;
            s2 <= s1;
            for (int i = 0; i < N_HOLES; i++) sh[i] <= {sh[i][DB_LEN-2:0], s2[i]};
            level <= all1 | (level & ~all0);
            getball <= all1 & ~level;
            if (is_rst) begin
                ball_num <= CNT_W'(BALLS_INIT);
                pending <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                ev_count <= '0;
                overflow <= 1'b0;
            end else begin
                if (is_get) ball_num <= ball_next;
                pending <= (pending & ~push_mask) | (is_get ? getball : '0);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                ev_count <= ev_count + CW'(push) - CW'(pop);
                overflow <= overflow | (|lost);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= idx;
    end
endmodule

// File: tb/tb_ball_tracker.sv
// tb_ball_tracker: randomized and directed stimulus against a behavioural model;
// a scoreboard queue of expected hole events is drained by a monitor on each handshake.
module tb_ball_tracker;
    localparam int N = 8, DB = 5, BI = 8, CW = 4, FD = 4;

    logic clk = 1'b0, rst = 1'b1, ev_ready = 1'b0;
    logic [N-1:0] ball = '0, getball;
    logic [2:0] state = 3'd0;
    logic [CW-1:0] ball_num;
    logic balls_out, ev_valid, overflow;
    logic [$clog2(N)-1:0] ev_hole;
    logic [$clog2(FD):0] ev_count;

    ball_tracker #(.N_HOLES(N), .DB_LEN(DB), .BALLS_INIT(BI), .CNT_W(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .ball(ball), .state(state), .getball(getball),
        .ball_num(ball_num), .balls_out(balls_out), .ev_valid(ev_valid), .ev_hole(ev_hole),
        .ev_ready(ev_ready), .ev_count(ev_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model: each hole's sensor history, pending set, event queue, ball count.
    logic [DB+1:0] hist [N];
    bit lvl [N], gb [N], pend [N], ovf;
    int bn, mq[$], exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i] = '0; lvl[i] = 0; gb[i] = 0; pend[i] = 0;
        end
        bn = BI; ovf = 0; mq.delete(); exp_q.delete();
    endtask

    task automatic model_step();
        int gcnt, pidx;
        bit a1, a0;
        gcnt = 0;
        for (int i = 0; i < N; i++) gcnt += int'(gb[i]);
        if (state == 3'd0) begin
            bn = BI; ovf = 0; mq.delete(); exp_q.delete();
            for (int i = 0; i < N; i++) pend[i] = 0;
        end else begin
            if (state == 3'd3) bn = (bn > gcnt) ? bn - gcnt : 0;
            if (ev_ready && mq.size() > 0) void'(mq.pop_front());
            pidx = -1;
            for (int i = 0; i < N; i++) if (pend[i] && pidx < 0) pidx = i;
            if (pidx >= 0 && mq.size() < FD) begin
                mq.push_back(pidx); exp_q.push_back(pidx); pend[pidx] = 0;
            end
            if (state == 3'd3)
                for (int i = 0; i < N; i++) if (gb[i]) begin
                    if (pend[i]) ovf = 1;
                    pend[i] = 1;
                end
        end
        // Level follows the window of DB samples that entered two cycles ago.
        for (int i = 0; i < N; i++) begin
            a1 = &hist[i][DB+1:2];
            a0 = ~|hist[i][DB+1:2];
            gb[i] = a1 && !lvl[i];
            if (a1) lvl[i] = 1; else if (a0) lvl[i] = 0;
            hist[i] = {hist[i][DB:0], ball[i]};
        end
    endtask

    function automatic int gb_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (gb[i]) v |= (1 << i);
        return v;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset(); else model_step();
        end
    end

    initial begin
        int h;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("getball", int'(getball), gb_vec());
                chk("ball_num", int'(ball_num), bn);
                chk("balls_out", int'(balls_out), int'(bn == 0));
                chk("ev_count", int'(ev_count), mq.size());
                chk("ev_valid", int'(ev_valid), int'(mq.size() > 0));
                chk("overflow", int'(overflow), int'(ovf));
                if (ev_valid && ev_ready && state != 3'd0) begin
                    if (exp_q.size() == 0) chk("ev_hole_unexpected", int'(ev_hole), -1);
                    else begin
                        h = exp_q.pop_front();
                        chk("ev_hole", int'(ev_hole), h);
                    end
                end
            end
        end
    end

    task automatic hold(input logic [N-1:0] m, input int n);
        ball = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic hit(input logic [N-1:0] m);
        hold(m, DB + 4);
        hold('0, DB + 4);
    endtask

    initial begin
        int rp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ball_num", int'(ball_num), BI);
        chk("reset_ev_valid", int'(ev_valid), 0);
        state = 3'd3;
        hold(8'h04, 20);
        hold('0, 12);
        chk("single_hit_ball_num", int'(ball_num), BI - 1);
        ev_ready = 1'b1;
        hold('0, 3);
        for (int k = 0; k < 30; k++) hold(ball ^ 8'h01, 1);
        hold('0, 12);
        hit(8'h62);
        hold('0, 6);
        ev_ready = 1'b0;
        state = 3'd0;
        hold('0, 2);
        state = 3'd3;
        for (int k = 0; k < 6; k++) hit(N'(1) << (k + 1));
        chk("full_ev_count", int'(ev_count), FD);
        chk("full_overflow", int'(overflow), 0);
        ev_ready = 1'b1;
        hold('0, 10);
        state = 3'd0;
        hold('0, 2);
        state = 3'd3;
        for (int k = 0; k < 9; k++) hit(N'(1) << (k % N));
        chk("sat_balls_out", int'(balls_out), 1);
        state = 3'd0;
        hold('0, 2);
        chk("reload_ball_num", int'(ball_num), BI);
        chk("reload_ev_count", int'(ev_count), 0);
        for (int blk = 0; blk < 15; blk++) begin
            rp = $urandom_range(2) * 50;
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < N; i++) if ($urandom_range(11) == 0) ball[i] = ~ball[i];
                rp = rp;
                ev_ready = $urandom_range(99) < rp;
                h_state();
                @(negedge clk);
            end
        end
        state = 3'd0;
        hold('0, 2);
        state = 3'd3;
        ev_ready = 1'b0;
        hit(8'h01);
        hit(8'h02);
        chk("pre_rst_ev_count", int'(ev_count), 2);
        hold(8'h80, 3);
        #3 rst = 1'b1;
        #1;
        chk("async_ball_num", int'(ball_num), BI);
        chk("async_ev_valid", int'(ev_valid), 0);
        chk("async_ev_count", int'(ev_count), 0);
        chk("async_getball", int'(getball), 0);
        chk("async_overflow", int'(overflow), 0);
        chk("async_balls_out", int'(balls_out), 0);
        ball = '0;
        @(negedge clk);
        rst = 1'b0;
        hold('0, 4);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    task automatic h_state();
        int r;
        r = $urandom_range(99);
        state = (r < 85) ? 3'd3 : (r < 98) ? 3'($urandom_range(7, 1)) : 3'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
